alu_ctrl_issue: RTL and testbench

- Issue stage that decodes instruction fields into the 4-bit ALU control code and hands the code and operands to the 64-bit execute ALU.
- Sits between decode and the ALU. Produces the exact code set the ALU consumes.
- Registered valid/ready interface on both sides, with a 2-entry skid buffer, synchronous flush and illegal-operation flagging.

---
 rtl/alu_ctrl_issue.sv | 190 +++++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_issue.sv
// Issue stage: decodes alu_op/funct3/funct7 into the 4-bit ALU control code and
// hands code, operands and tag to the execute ALU through a 2-entry skid buffer.
// Optional macro ALU_ILLEGAL_CNT_EN adds a saturating illegal_count output.
module alu_ctrl_issue #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_control,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef ALU_ILLEGAL_CNT_EN
    ,
    output logic [15:0]      illegal_count
`endif
);

    localparam int ENT_W = 5 + 2 * XLEN + TAG_W;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    // Returns {illegal, code}; illegal entries carry the all-ones code so the ALU yields 0.
    function automatic logic [4:0] decode_op(input logic [1:0] op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [3:0] code;
        logic       ill;
        logic       is_r;
        logic       f7_zero;
        logic       f7_alt;
        logic       shamt_hi_zero;
        logic       shamt_hi_sra;
        is_r          = (op == 2'b10);
        f7_zero       = (f7 == 7'b0000000);
        f7_alt        = (f7 == 7'b0100000);
        shamt_hi_zero = (f7[6:1] == 6'b000000);
        shamt_hi_sra  = (f7[6:1] == 6'b010000);
        code          = ALU_ADD;
        ill           = 1'b0;
        case (op)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_SUB;
            default: begin
                case (f3)
                    3'b000: begin
                        code = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
                        ill  = is_r && !(f7_zero || f7_alt);
                    end
                    3'b111: begin
                        code = ALU_AND;
                        ill  = is_r && !f7_zero;
                    end
                    3'b110: begin
                        code = ALU_OR;
                        ill  = is_r && !f7_zero;
                    end
                    3'b100: begin
                        code = ALU_XOR;
                        ill  = is_r && !f7_zero;
                    end
                    3'b001: begin
                        code = ALU_SLL;
                        ill  = is_r ? !f7_zero : !shamt_hi_zero;
                    end
                    3'b101: begin
                        code = f7[5] ? ALU_SRA : ALU_SRL;
                        ill  = is_r ? !(f7_zero || f7_alt) : !(shamt_hi_zero || shamt_hi_sra);
                    end
                    default: begin
                        code = ALU_ILL;
                        ill  = 1'b1;
                    end
                endcase
            end
        endcase
        return {ill, (ill ? ALU_ILL : code)};
    endfunction

    logic [ENT_W-1:0] in_ent_s;
    logic [ENT_W-1:0] out_ent_r;
    logic [ENT_W-1:0] skid_ent_r;
    logic [ENT_W-1:0] out_ent_n_s;
    logic [ENT_W-1:0] skid_ent_n_s;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic             out_valid_n_s;
    logic             skid_valid_n_s;
    logic             accept_s;
    logic             drain_s;
    logic             out_free_s;

    assign in_ent_s   = {decode_op(in_alu_op, in_funct3, in_funct7), in_a, in_b, in_tag};
    assign accept_s   = in_valid && in_ready_r && !flush;
    assign drain_s    = out_valid_r && out_ready;
    assign out_free_s = !out_valid_r || drain_s;

    // Next-state for output and skid registers; skid refills the output before any new entry.
    always_comb begin
        out_valid_n_s  = out_valid_r;
        skid_valid_n_s = skid_valid_r;
        out_ent_n_s    = out_ent_r;
        skid_ent_n_s   = skid_ent_r;
        if (flush) begin
            out_valid_n_s  = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_ent_n_s    = skid_ent_r;
                out_valid_n_s  = 1'b1;
                skid_valid_n_s = 1'b0;
            end else if (accept_s) begin
                out_ent_n_s   = in_ent_s;
                out_valid_n_s = 1'b1;
            end else begin
                out_valid_n_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_ent_n_s   = in_ent_s;
            skid_valid_n_s = 1'b1;
        end else begin
            skid_valid_n_s = skid_valid_r;
        end
    end

    // Pipeline state registers; in_ready mirrors the next skid occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_ent_r    <= {ENT_W{1'b0}};
            skid_ent_r   <= {ENT_W{1'b0}};
        end else begin
            out_valid_r  <= out_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= !skid_valid_n_s;
            out_ent_r    <= out_ent_n_s;
            skid_ent_r   <= skid_ent_n_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = out_valid_r;
    assign out_illegal     = out_ent_r[ENT_W-1];
    assign out_alu_control = out_ent_r[ENT_W-2 -: 4];
    assign out_a           = out_ent_r[TAG_W+XLEN +: XLEN];
    assign out_b           = out_ent_r[TAG_W +: XLEN];
    assign out_tag         = out_ent_r[TAG_W-1:0];

`ifdef ALU_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt_r;

    // Saturating count of illegal entries consumed downstream; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt_r <= 16'h0000;
        end else if (drain_s && out_illegal && (ill_cnt_r != 16'hFFFF)) begin
            ill_cnt_r <= ill_cnt_r + 16'h0001;
        end else begin
            ill_cnt_r <= ill_cnt_r;
        end
    end

    assign illegal_count = ill_cnt_r;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: directed decode vectors, backpressure,
// flush, and (with ALU_ILLEGAL_CNT_EN) the saturating illegal counter.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_a, in_b, out_a, out_b;
    logic [4:0]  in_tag, out_tag;
    logic [3:0]  out_alu_control;
`ifdef ALU_ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
`endif

    alu_ctrl_issue #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_control(out_alu_control), .out_a(out_a), .out_b(out_b),
        .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef ALU_ILLEGAL_CNT_EN
        , .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  code;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   xfer_cyc [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks hold-while-stalled.
    logic        stall_seen = 1'b0;
    exp_t        held;
    always @(negedge clk) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_code", {60'd0, out_alu_control}, {60'd0, held.code});
                chk("hold_a", out_a, held.a);
                chk("hold_b", out_b, held.b);
                chk("hold_tag", {59'd0, out_tag}, {59'd0, held.tag});
                chk("hold_ill", {63'd0, out_illegal}, {63'd0, held.ill});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_issue_tag", {59'd0, out_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("code", {60'd0, out_alu_control}, {60'd0, e.code});
                    chk("a", out_a, e.a);
                    chk("b", out_b, e.b);
                    chk("tag", {59'd0, out_tag}, {59'd0, e.tag});
                    chk("illegal", {63'd0, out_illegal}, {63'd0, e.ill});
                end
                xfer_cyc[out_tag] = cyc;
            end
            stall_seen = out_valid && !out_ready && !flush;
            held = '{code: out_alu_control, a: out_a, b: out_b, tag: out_tag, ill: out_illegal};
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [3:0] code, input logic ill);
        logic accepted;
        accepted  = 1'b0;
        in_alu_op = op; in_funct3 = f3; in_funct7 = f7;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        for (int w = 0; w < 50 && !accepted; w++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                q.push_back('{code: code, a: a, b: b, tag: tag, ill: ill});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_alu_op = 2'b00; in_funct3 = 3'b000; in_funct7 = 7'b0000000;
        in_a = 64'd0; in_b = 64'd0; in_tag = 5'd0;
        for (int i = 0; i < 32; i++) xfer_cyc[i] = -100;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_code", {60'd0, out_alu_control}, 64'd0);
        chk("rst_a", out_a, 64'd0);
        chk("rst_b", out_b, 64'd0);
        chk("rst_tag", {59'd0, out_tag}, 64'd0);
        chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
        @(posedge clk);
        #1;

        // First entry: one-cycle latency
        send(2'b10, 3'b000, 7'b0100000, 64'd10, 64'd3, 5'd7, 4'b0110, 1'b0);
        @(negedge clk);
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;

        // Decode sweep, back to back
        send(2'b10, 3'b111, 7'b0000000, 64'h11, 64'h21, 5'd10, 4'b0000, 1'b0);
        send(2'b10, 3'b110, 7'b0000000, 64'h12, 64'h22, 5'd11, 4'b0001, 1'b0);
        send(2'b10, 3'b100, 7'b0000000, 64'h13, 64'h23, 5'd12, 4'b0100, 1'b0);
        send(2'b10, 3'b001, 7'b0000000, 64'h14, 64'h24, 5'd13, 4'b1000, 1'b0);
        send(2'b10, 3'b101, 7'b0100000, 64'h15, 64'h25, 5'd14, 4'b1010, 1'b0);
        send(2'b11, 3'b101, 7'b0000001, 64'h16, 64'h26, 5'd15, 4'b1001, 1'b0);
        send(2'b11, 3'b000, 7'b0100000, 64'h17, 64'h27, 5'd16, 4'b0010, 1'b0);
        send(2'b00, 3'b110, 7'b1010101, 64'h18, 64'h28, 5'd17, 4'b0010, 1'b0);
        send(2'b01, 3'b011, 7'b0100000, 64'h19, 64'h29, 5'd18, 4'b0110, 1'b0);
        send(2'b10, 3'b101, 7'b0000000, 64'h1A, 64'h2A, 5'd19, 4'b1001, 1'b0);
        send(2'b11, 3'b101, 7'b0100001, 64'h1B, 64'h2B, 5'd20, 4'b1010, 1'b0);
        // Illegal entries are still issued
        send(2'b10, 3'b010, 7'b0000000, 64'h31, 64'h41, 5'd21, 4'b1111, 1'b1);
        send(2'b10, 3'b111, 7'b0000001, 64'h32, 64'h42, 5'd22, 4'b1111, 1'b1);
        send(2'b11, 3'b001, 7'b0100000, 64'h33, 64'h43, 5'd23, 4'b1111, 1'b1);
        send(2'b11, 3'b011, 7'b0000000, 64'h34, 64'h44, 5'd24, 4'b1111, 1'b1);
        send(2'b10, 3'b000, 7'b0000001, 64'h35, 64'h45, 5'd25, 4'b1111, 1'b1);
        drain();

        // Backpressure: fill output and skid, third entry waits
        out_ready = 1'b0;
        send(2'b10, 3'b000, 7'b0000000, 64'hA1, 64'hB1, 5'd1, 4'b0010, 1'b0);
        send(2'b10, 3'b110, 7'b0000000, 64'hA2, 64'hB2, 5'd2, 4'b0001, 1'b0);
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        fork
            send(2'b10, 3'b100, 7'b0000000, 64'hA3, 64'hB3, 5'd3, 4'b0100, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("order_1_2", xfer_cyc[2] - xfer_cyc[1], 64'd1);
        chk("order_2_3", xfer_cyc[3] - xfer_cyc[2], 64'd1);

        // Flush with both registers full; concurrent input is discarded
        out_ready = 1'b0;
        send(2'b10, 3'b000, 7'b0000000, 64'hC4, 64'hD4, 5'd4, 4'b0010, 1'b0);
        send(2'b10, 3'b000, 7'b0000000, 64'hC5, 64'hD5, 5'd5, 4'b0010, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; in_tag = 5'd8; in_alu_op = 2'b00;
        @(posedge clk);
        q.delete();
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(2'b10, 3'b111, 7'b0000000, 64'hE9, 64'hF9, 5'd9, 4'b0000, 1'b0);
        drain();

`ifdef ALU_ILLEGAL_CNT_EN
        pulse_reset();
        @(negedge clk);
        chk("cnt_after_reset", {48'd0, illegal_count}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            send(2'b10, 3'b010, 7'b0000000, 64'd1, 64'd2, 5'd26, 4'b1111, 1'b1);
        drain();
        chk("cnt_three", {48'd0, illegal_count}, 64'd3);
        pulse_reset();
        @(negedge clk);
        chk("cnt_reset_again", {48'd0, illegal_count}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 65535; i++)
            send(2'b11, 3'b011, 7'b0000000, 64'd5, 64'd6, 5'd27, 4'b1111, 1'b1);
        drain();
        chk("cnt_max", {48'd0, illegal_count}, 64'hFFFF);
        send(2'b11, 3'b010, 7'b0000000, 64'd5, 64'd6, 5'd28, 4'b1111, 1'b1);
        drain();
        chk("cnt_saturate", {48'd0, illegal_count}, 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
